// File: rtl/rst_seq_pkg.sv
// Shared types and default constants for the reset sequencer.
package rst_seq_pkg;

   typedef enum logic [2:0] {
      ST_RESET  = 3'd0,
      ST_HOLD   = 3'd1,
      ST_PERIPH = 3'd2,
      ST_RUN    = 3'd3,
      ST_SWRST  = 3'd4
   } rst_seq_state_e;

   localparam int unsigned DEF_SYNC_STAGES = 2;
   localparam int unsigned DEF_HOLD_CYCLES = 16;
   localparam int unsigned DEF_STAGE_GAP   = 4;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/rst_sync_cell.sv
// Flop-chain synchroniser with asynchronous active-low clear.
// Clearing forces q low at once; a high d reaches q SYNC_STAGES edges later.
module rst_sync_cell
   import rst_seq_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;

   // Shift d through the chain; the async clear empties it immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      end
   end

   assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq_xilusp.sv
// Reset sequencer: asserts resets asynchronously, releases them synchronously
// to clk_sys after a hold period, peripherals first and the core STAGE_GAP
// cycles later.
// Optional build macro RST_SEQ_SWRST_EN adds a level-sensitive software reset
// request (sw_rst_req_i) and a one-cycle acknowledge (sw_rst_ack_o).
module rst_seq_xilusp
   import rst_seq_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
   parameter int unsigned STAGE_GAP   = DEF_STAGE_GAP
) (
   input  logic clk_sys,
   input  logic rst_sys_n,
   input  logic pll_locked_i,
`ifdef RST_SEQ_SWRST_EN
   input  logic sw_rst_req_i,
   output logic sw_rst_ack_o,
`endif
   output logic rst_periph_n_o,
   output logic rst_core_n_o,
   output logic rst_done_o
);

   localparam int unsigned CNT_W = $clog2(max_u(HOLD_CYCLES, STAGE_GAP) + 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);

   logic rst_sync_n;
   logic lock_sync;
   logic ok;

   rst_seq_state_e   state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_inc;
   logic             periph_q, periph_d;
   logic             core_q, core_d;
   logic             done_q, done_d;
`ifdef RST_SEQ_SWRST_EN
   logic             ack_q, ack_d;
`endif

   rst_sync_cell #(.SYNC_STAGES(SYNC_STAGES)) u_rst_sync (
      .clk   (clk_sys),
      .rst_n (rst_sys_n),
      .d     (1'b1),
      .q     (rst_sync_n)
   );

   // The lock chain is also cleared by rst_sys_n so a fresh sequence always
   // waits for a full re-synchronisation of pll_locked_i.
   rst_sync_cell #(.SYNC_STAGES(SYNC_STAGES)) u_lock_sync (
      .clk   (clk_sys),
      .rst_n (rst_sys_n),
      .d     (pll_locked_i),
      .q     (lock_sync)
   );

   assign ok      = rst_sync_n & lock_sync;
   assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

   // Next state, counter and next output values; outputs are decoded from
   // the next state so every output leaves a flop.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_RESET: begin
            cnt_d = '0;
            if (ok) begin
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (!ok) begin
               state_d = ST_RESET;
               cnt_d   = '0;
            end else if (cnt_q == HOLD_LAST) begin
               state_d = ST_PERIPH;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ST_PERIPH: begin
            if (!ok) begin
               state_d = ST_RESET;
               cnt_d   = '0;
            end else if (cnt_q == GAP_LAST) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ST_RUN: begin
            cnt_d = '0;
            if (!ok) begin
               state_d = ST_RESET;
`ifdef RST_SEQ_SWRST_EN
            end else if (sw_rst_req_i) begin
               state_d = ST_SWRST;
`endif
            end
         end
`ifdef RST_SEQ_SWRST_EN
         ST_SWRST: begin
            cnt_d   = '0;
            state_d = ok ? ST_HOLD : ST_RESET;
         end
`endif
         default: begin
            state_d = ST_RESET;
            cnt_d   = '0;
         end
      endcase

      periph_d = (state_d == ST_PERIPH) || (state_d == ST_RUN);
      core_d   = (state_d == ST_RUN);
      done_d   = (state_d == ST_RUN);
`ifdef RST_SEQ_SWRST_EN
      ack_d    = (state_d == ST_SWRST);
`endif
   end

   // State, counter and registered outputs; rst_sys_n clears all at once.
   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         state_q  <= ST_RESET;
         cnt_q    <= '0;
         periph_q <= 1'b0;
         core_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef RST_SEQ_SWRST_EN
         ack_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         periph_q <= periph_d;
         core_q   <= core_d;
         done_q   <= done_d;
`ifdef RST_SEQ_SWRST_EN
         ack_q    <= ack_d;
`endif
      end
   end

   assign rst_periph_n_o = periph_q;
   assign rst_core_n_o   = core_q;
   assign rst_done_o     = done_q;
`ifdef RST_SEQ_SWRST_EN
   assign sw_rst_ack_o   = ack_q;
`endif

endmodule
